icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
// - Instruction-bus responder: serves fetch-stage ibus requests from a direct-mapped, read-only line cache.
// - On a miss, refills the line from memory over a burst read port; uncached region goes through single-beat reads.
// - Sits between the fetch stage (ibus_req_t/ibus_resp_t) and the core's memory-side bus arbiter.
// PARAMETERS
// - SETS        64  number of lines, power of two
// - LINE_BEATS  4   64-bit beats per line (line = 8*LINE_BEATS bytes), power of two
// - UNCACHED_HI 1'b0  fetches with addr[31]==UNCACHED_HI bypass the cache
// PORTS
// - clk          in   1    clock
// - rst          in   1    synchronous, active-high reset
// - ireq         in   ibus_req_t   .valid, .addr[63:0] from fetch; addr may change any cycle
// - iresp        out  ibus_resp_t  .addr_ok, .data_ok, .data[31:0] instruction
// - mreq_valid   out  1    memory read request valid
// - mreq_addr    out  64   line-aligned (cached) or word-aligned (uncached) address
// - mreq_len     out  8    beats-1 (LINE_BEATS-1 cached, 0 uncached)
// - mresp_ready  in   1    beat valid on mresp_data this cycle
// - mresp_last   in   1    final beat of burst
// - mresp_data   in   64   beat data
// BEHAVIOUR
// - Reset: state IDLE, all valid bits 0, iresp.addr_ok=0, data_ok=0, data=0, mreq_valid=0, beat counter 0.
//   rst mid-REFILL/UNCACHED aborts immediately; partially filled line stays invalid.
// - Index = addr[log2(8*LINE_BEATS) +: log2(SETS)]; tag = addr[63:log2(8*LINE_BEATS*SETS)]; addr[1:0] ignored.
// - Word select: beat = addr[3 +: log2(LINE_BEATS)], half = addr[2] (1 -> data[63:32]).
// - FSM IDLE: if ireq.valid, latch addr into req_q, addr_ok=1 for that cycle, go LOOKUP.
// - LOOKUP: if ireq.addr != req_q, drop, go IDLE (no data_ok). Else if uncached, go UNCACHED.
//   Else hit (valid & tag match): data_ok=1, data=selected word, go IDLE. Miss: go REFILL.
//   Hit latency: 2 cycles from ireq.valid with stable addr; back-to-back hits every 2 cycles.
// - REFILL: mreq_valid=1, addr = req_q line-aligned, len=LINE_BEATS-1, held until last beat.
//   Each mresp_ready writes beat[cnt], cnt++; on mresp_last: set valid+tag, cnt=0, go LOOKUP (re-check).
//   Beats arrive in order starting at beat 0; mresp_last on any beat other than LINE_BEATS-1 is a protocol error,
//   line is still marked valid (garbage allowed) - bench must not generate it.
// - UNCACHED: mreq_valid=1, addr=req_q & ~7, len=0; on mresp_ready: if ireq.addr==req_q, data_ok=1 with word,
//   else discard; go IDLE. Never allocates.
// - iresp.data_ok is a one-cycle pulse and is asserted only when ireq.addr equals the address whose data is
//   returned that cycle; data is 0 whenever data_ok=0.
// - Refill is never cancelled by an ireq.addr change (line completes, then re-lookup may miss/drop).
// - ireq.valid low during REFILL/UNCACHED: transaction completes, no data_ok, return to IDLE.
// - Storage: tags/valid in flops; data in flop array or inferred RAM with read in LOOKUP (1-cycle).
// CONFIGURATION
// - ICACHE_FLUSH_EN defined: extra input port flush (1) (fence.i). flush high in IDLE/LOOKUP clears all
//   valid bits next cycle and forces IDLE, no data_ok that cycle; flush during REFILL is recorded and applied
//   on the refill's last beat (refilled line also left invalid), then IDLE.
// - Not defined: no flush port; valid bits clear only on rst.
// TESTING
// - Cold miss: rst, ireq.addr=0x8000_0000 held -> mreq len=3 addr 0x8000_0000, 4 beats, then data_ok with word0.
// - Hit: after fill, addr=0x8000_0004 -> data_ok 2 cycles later, data=beat0[63:32], no mreq_valid.
// - Addr change mid-refill: switch addr to 0x8000_0100 during beat 2 -> refill completes, no data_ok for 0x..00, then miss on 0x..100.
// - Uncached: addr=0x0000_1008 -> mreq addr 0x1008 len=0; one beat data 0xDEAD_BEEF_1234_5678 -> data 0x1234_5678; re-fetch re-reads memory.
// - Conflict: fill 0x8000_0000 then 0x8000_0800 (same index, SETS=64) -> second refills, first then misses.
// - Reset mid-refill after beat 1 -> mreq_valid=0 next cycle; refetch 0x8000_0000 misses and refills fully.

Source files
------------

// File: rtl/icache.sv
// icache - direct-mapped, read-only instruction cache for the fetch stage.
//
// Serves ibus fetches from a SETS x LINE_BEATS x 64-bit line store. A miss
// refills the whole line over a burst read port; fetches whose addr[31]
// equals UNCACHED_HI bypass the cache with a single-beat read.
//
// Optional feature macro: ICACHE_FLUSH_EN (adds the `flush` input, fence.i).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ireq              fetch request  {valid, addr[63:0]}
//   iresp             fetch response {addr_ok, data_ok, data[31:0]}
//   mreq_valid/addr/len  memory read request (len = beats-1)
//   mresp_ready/last/data  memory beat return
//   flush             (ICACHE_FLUSH_EN only) invalidate all lines

package icache_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

module icache
    import icache_pkg::*;
#(
    parameter int   SETS        = 64,
    parameter int   LINE_BEATS  = 4,
    parameter logic UNCACHED_HI = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  ibus_req_t   ireq,
    output ibus_resp_t  iresp,
    output logic        mreq_valid,
    output logic [63:0] mreq_addr,
    output logic [7:0]  mreq_len,
    input  logic        mresp_ready,
    input  logic        mresp_last,
`ifdef ICACHE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic [63:0] mresp_data
);
    localparam int OFF_W  = $clog2(8 * LINE_BEATS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int TAG_W  = 64 - OFF_W - IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_UNCACHED} state_t;

    state_t                    r_state, w_next;
    logic [63:0]               r_req_q;
    logic [SETS-1:0]           r_valid;
    logic [TAG_W-1:0]          r_tag  [SETS];
    logic [63:0]               r_data [SETS*LINE_BEATS];
    logic [BEAT_W-1:0]         r_cnt;
    logic                      r_drop;        // ireq.valid fell during a memory transaction
    logic                      r_flush_pend;  // flush seen while memory was busy

    logic                      w_flush;
    logic [IDX_W-1:0]          w_idx;
    logic [TAG_W-1:0]          w_tag;
    logic [IDX_W+BEAT_W-1:0]   w_rd_addr;
    logic [63:0]               w_line_word;
    logic [31:0]               w_hit_word, w_unc_word;
    logic                      w_same, w_uncached, w_hit, w_beat_wr, w_fill_done;

`ifdef ICACHE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_idx       = r_req_q[OFF_W +: IDX_W];
    assign w_tag       = r_req_q[63 -: TAG_W];
    assign w_rd_addr   = {w_idx, r_req_q[3 +: BEAT_W]};
    assign w_line_word = r_data[w_rd_addr];
    assign w_hit_word  = r_req_q[2] ? w_line_word[63:32] : w_line_word[31:0];
    assign w_unc_word  = r_req_q[2] ? mresp_data[63:32]  : mresp_data[31:0];
    assign w_same      = ireq.valid && (ireq.addr == r_req_q);
    assign w_uncached  = (r_req_q[31] == UNCACHED_HI);
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_beat_wr   = (r_state == S_REFILL) && mresp_ready;
    assign w_fill_done = w_beat_wr && mresp_last;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        iresp      = '0;
        mreq_valid = 1'b0;
        mreq_addr  = '0;
        mreq_len   = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_flush && ireq.valid) begin
                    iresp.addr_ok = 1'b1;
                    w_next        = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_flush || !w_same) w_next = S_IDLE;
                else if (w_uncached)    w_next = S_UNCACHED;
                else if (w_hit) begin
                    iresp.data_ok = 1'b1;
                    iresp.data    = w_hit_word;
                    w_next        = S_IDLE;
                end
                else w_next = S_REFILL;
            end
            S_REFILL: begin
                mreq_valid = 1'b1;
                mreq_addr  = {r_req_q[63:OFF_W], {OFF_W{1'b0}}};
                mreq_len   = 8'(LINE_BEATS - 1);
                if (w_fill_done) begin
                    // A completed line is always re-looked-up unless the
                    // requester went away or a flush is owed.
                    if (r_flush_pend || w_flush || r_drop || !ireq.valid) w_next = S_IDLE;
                    else                                                  w_next = S_LOOKUP;
                end
            end
            S_UNCACHED: begin
                mreq_valid = 1'b1;
                mreq_addr  = r_req_q & ~64'h7;
                mreq_len   = 8'd0;
                if (mresp_ready) begin
                    if (w_same && !r_drop) begin
                        iresp.data_ok = 1'b1;
                        iresp.data    = w_unc_word;
                    end
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Outputs read as idle while reset is held.
        if (rst) begin
            iresp      = '0;
            mreq_valid = 1'b0;
            mreq_addr  = '0;
            mreq_len   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q      <= '0;
            r_valid      <= '0;
            r_cnt        <= '0;
            r_drop       <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_flush) r_valid <= '0;
                    else if (ireq.valid) begin
                        r_req_q <= ireq.addr;
                        r_drop  <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    if (w_flush) r_valid <= '0;
                    // Invalidate before the first beat lands so an aborted
                    // refill never leaves a stale tag over new data.
                    else if (w_next == S_REFILL) r_valid[w_idx] <= 1'b0;
                end
                S_REFILL: begin
                    if (!ireq.valid) r_drop <= 1'b1;
                    if (w_flush)     r_flush_pend <= 1'b1;
                    if (w_beat_wr)   r_cnt <= r_cnt + 1'b1;
                    if (w_fill_done) begin
                        r_cnt        <= '0;
                        r_tag[w_idx] <= w_tag;
                        if (r_flush_pend || w_flush) begin
                            r_valid      <= '0;
                            r_flush_pend <= 1'b0;
                        end else begin
                            r_valid[w_idx] <= 1'b1;
                        end
                    end
                end
                S_UNCACHED: begin
                    if (!ireq.valid) r_drop <= 1'b1;
                    if (w_flush)     r_flush_pend <= 1'b1;
                    if (mresp_ready && (r_flush_pend || w_flush)) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line store: no reset, written only by refill beats.
    always_ff @(posedge clk) begin
        if (!rst && w_beat_wr) r_data[{w_idx, r_cnt}] <= mresp_data;
    end

endmodule

// File: tb/tb_icache.sv
module tb_icache;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    ibus_req_t   ireq = '0;
    ibus_resp_t  iresp;
    logic        mreq_valid;
    logic [63:0] mreq_addr;
    logic [7:0]  mreq_len;
    logic        mresp_ready = 1'b0;
    logic        mresp_last  = 1'b0;
    logic [63:0] mresp_data  = '0;

    int errors = 0;
    int checks = 0;

    icache dut (
        .clk(clk), .rst(rst), .ireq(ireq), .iresp(iresp),
        .mreq_valid(mreq_valid), .mreq_addr(mreq_addr), .mreq_len(mreq_len),
        .mresp_ready(mresp_ready), .mresp_last(mresp_last), .mresp_data(mresp_data)
    );

    always #5 clk = ~clk;

    // ---- memory model ----
    function automatic logic [63:0] mem(input logic [63:0] a);
        if (a == 64'h1008) return 64'hDEAD_BEEF_1234_5678;
        return {a[31:0] ^ 32'h5A5A_0000, a[31:0] ^ 32'h0000_C3C3};
    endfunction

    function automatic logic [31:0] exp_word(input logic [63:0] a);
        logic [63:0] b;
        b = mem({a[63:3], 3'b000});
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---- memory responder: one beat per cycle while mreq_valid ----
    int          nreq = 0;
    int          nbeats = 0;
    int          bi = 0;
    int          cur_bi = -1;
    bit          busy = 0;
    logic [63:0] rbase, last_addr = '0;
    logic [7:0]  rlen, last_len = '0;

    always begin
        @(posedge clk);
        #1;
        mresp_ready = 1'b0;
        mresp_last  = 1'b0;
        mresp_data  = '0;
        if (mreq_valid) begin
            if (!busy) begin
                busy = 1; rbase = mreq_addr; rlen = mreq_len; bi = 0;
                nreq++; last_addr = mreq_addr; last_len = mreq_len;
            end
            cur_bi      = bi;
            mresp_ready = 1'b1;
            mresp_data  = mem(rbase + 64'(bi) * 64'd8);
            mresp_last  = (bi == int'(rlen));
            nbeats++;
            bi++;
            if (bi > int'(rlen)) busy = 0;
        end else begin
            busy = 0;
        end
    end

    // ---- scoreboard ----
    logic [31:0] sbq[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (iresp.data_ok) begin
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_data_ok: got data 0x%0h with nothing expected", iresp.data);
                end else begin
                    chk("sb_data", 64'(iresp.data), 64'(sbq.pop_front()));
                end
            end else if (iresp.data != 32'd0) begin
                checks++; errors++;
                $display("FAIL data_idle_zero: got 0x%0h expected 0", iresp.data);
            end
        end
    end

    // ---- fetch helper: hold addr until data_ok ----
    task automatic fetch(input logic [63:0] a, input int exp_nreq, input int exp_lat);
        int  n0, c;
        bit  seen_ok, seen_aok;
        logic [31:0] dummy;
        @(posedge clk); #1;
        n0 = nreq;
        sbq.push_back(exp_word(a));
        ireq.valid = 1'b1;
        ireq.addr  = a;
        seen_ok = 0; seen_aok = 0;
        for (c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (iresp.addr_ok) seen_aok = 1;
            if (iresp.data_ok) begin seen_ok = 1; break; end
        end
        chk("data_ok_seen", 64'(seen_ok), 64'd1);
        if (!seen_ok && sbq.size() > 0) dummy = sbq.pop_back();
        chk("addr_ok_seen", 64'(seen_aok), 64'd1);
        chk("mreq_count", 64'(nreq - n0), 64'(exp_nreq));
        if (exp_nreq > 0) begin
            chk("mreq_addr", last_addr, a[31] ? (a & ~64'h1F) : (a & ~64'h7));
            chk("mreq_len", 64'(last_len), a[31] ? 64'd3 : 64'd0);
        end
        if (exp_lat > 0) chk("hit_latency", 64'(c), 64'(exp_lat));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; ireq = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic [63:0] addr;
        int          nreq;  // memory requests expected
        int          lat;   // expected data_ok cycle, 0 = not checked
    } vec_t;

    vec_t vt[10];

    initial begin
        int n0, b0, c;
        bit found;
        logic [31:0] dummy;

        vt[0] = '{64'h8000_0000, 1, 0};  // cold miss
        vt[1] = '{64'h8000_0004, 0, 2};  // hit, upper half of beat 0
        vt[2] = '{64'h8000_0018, 0, 2};  // hit, beat 3 low
        vt[3] = '{64'h8000_001C, 0, 2};  // hit, beat 3 high
        vt[4] = '{64'h0000_1008, 1, 0};  // uncached
        vt[5] = '{64'h0000_1008, 1, 0};  // uncached again re-reads memory
        vt[6] = '{64'h8000_0800, 1, 0};  // same index, new tag
        vt[7] = '{64'h8000_0000, 1, 0};  // evicted -> miss
        vt[8] = '{64'h8000_0820, 1, 0};  // index 1
        vt[9] = '{64'h8000_0834, 0, 2};  // hit in index 1

        // reset state, with a live request held during reset
        ireq.valid = 1'b1; ireq.addr = 64'h8000_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_ok", 64'(iresp.addr_ok), 64'd0);
        chk("rst_data_ok", 64'(iresp.data_ok), 64'd0);
        chk("rst_mreq_valid", 64'(mreq_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; ireq = '0;
        @(negedge clk);
        chk("idle_addr_ok", 64'(iresp.addr_ok), 64'd0);
        chk("idle_mreq_valid", 64'(mreq_valid), 64'd0);

        for (int i = 0; i < 10; i++) fetch(vt[i].addr, vt[i].nreq, vt[i].lat);
        @(posedge clk); #1 ireq = '0;

        // address change mid-refill: line 0 completes, no data_ok for it
        do_reset();
        @(posedge clk); #1;
        n0 = nreq;
        sbq.push_back(exp_word(64'h8000_0100));
        ireq.valid = 1'b1; ireq.addr = 64'h8000_0000;
        found = 0;
        for (c = 0; c < 60; c++) begin
            @(posedge clk);
            if (mresp_ready && cur_bi == 1) begin found = 1; break; end
        end
        chk("midrefill_beat1_seen", 64'(found), 64'd1);
        #1 ireq.addr = 64'h8000_0100;
        found = 0;
        for (c = 0; c < 80; c++) begin
            @(negedge clk);
            if (iresp.data_ok) begin found = 1; break; end
        end
        chk("midrefill_data_ok", 64'(found), 64'd1);
        if (!found && sbq.size() > 0) dummy = sbq.pop_back();
        chk("midrefill_mreq_count", 64'(nreq - n0), 64'd2);
        chk("midrefill_last_addr", last_addr, 64'h8000_0100);
        fetch(64'h8000_0000, 0, 2);      // first line finished filling
        @(posedge clk); #1 ireq = '0;

        // reset after beat 1 of a refill
        do_reset();
        @(posedge clk); #1;
        ireq.valid = 1'b1; ireq.addr = 64'h8000_0000;
        found = 0;
        for (c = 0; c < 60; c++) begin
            @(posedge clk);
            if (mresp_ready && cur_bi == 1) begin found = 1; break; end
        end
        chk("rstmid_beat1_seen", 64'(found), 64'd1);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_mreq_valid", 64'(mreq_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; ireq = '0;
        @(negedge clk);
        chk("rstmid_idle_mreq", 64'(mreq_valid), 64'd0);
        b0 = nbeats;
        fetch(64'h8000_0000, 1, 0);
        chk("rstmid_full_refill_beats", 64'(nbeats - b0), 64'd4);
        @(posedge clk); #1 ireq = '0;
        repeat (3) @(posedge clk);

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
